kanagawa_axi4_lite_responder: RTL and testbench

- Synthesizable AXI4-Lite subordinate (responder) backed by a register file of NUM_REGS words.
- Completes transactions issued by the simulation AXI4-Lite initiator and by host-side AXI4-Lite masters; register contents are exported to fabric logic.
- Write address and write data are accepted independently, in either order.
- One outstanding write and one outstanding read at a time.

---
 rtl/kanagawa_axi4_lite_responder_if.sv | 33 +++
 rtl/kanagawa_axi4_lite_responder.sv | 163 ++++++++++++++++
 tb/tb_kanagawa_axi4_lite_responder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kanagawa_axi4_lite_responder_if.sv
// AXI4-Lite bus bundle between an initiator (master) and the register responder (slave).
interface kanagawa_axi4_lite_responder_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      awready;
    logic                      awvalid;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wready;
    logic                      wvalid;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bready;
    logic                      bvalid;
    logic [1:0]                bresp;
    logic                      arready;
    logic                      arvalid;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rready;
    logic                      rvalid;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/kanagawa_axi4_lite_responder.sv
// AXI4-Lite register-file responder; AW and W may arrive in either order.
// Define KANAGAWA_AXIL_RESPONDER_SLVERR_EN to answer out-of-range accesses with SLVERR.
module kanagawa_axi4_lite_responder #(
    parameter int unsigned          ADDR_WIDTH  = 12,
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    kanagawa_axi4_lite_responder_if.slave  bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFFS   = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS;
    localparam logic [IDX_W:0] NumRegsCmp = (IDX_W + 1)'(NUM_REGS);

    localparam logic [1:0] RespOkay = 2'b00;
`ifdef KANAGAWA_AXIL_RESPONDER_SLVERR_EN
    localparam logic [1:0] RespOor = 2'b10;
`else
    localparam logic [1:0] RespOor = RespOkay;
`endif

    typedef enum logic {WrIdle, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdData} rd_state_e;

    wr_state_e               wr_state_q;
    rd_state_e               rd_state_q;
    logic                    ready_en_q;
    logic                    aw_held_q;
    logic                    w_held_q;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_W-1:0]       w_strb_q;
    logic [1:0]              bresp_q;
    logic [1:0]              rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic                    aw_fire, w_fire, ar_fire, commit;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [STRB_W-1:0]       wr_strb;
    logic [IDX_W-1:0]        wr_idx, rd_idx;
    logic                    wr_hit, rd_hit;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    unused_addr_lsbs;

    // ready_en_q holds the readies low until the first edge after reset release
    assign bus.awready = ready_en_q && !aw_held_q && (wr_state_q == WrIdle);
    assign bus.wready  = ready_en_q && !w_held_q && (wr_state_q == WrIdle);
    assign bus.arready = ready_en_q && (rd_state_q == RdIdle);
    assign bus.bvalid  = (wr_state_q == WrResp);
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = (rd_state_q == RdData);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    assign aw_fire = bus.awvalid && bus.awready;
    assign w_fire  = bus.wvalid && bus.wready;
    assign ar_fire = bus.arvalid && bus.arready;

    assign wr_addr = aw_held_q ? aw_addr_q : bus.awaddr;
    assign wr_data = w_held_q ? w_data_q : bus.wdata;
    assign wr_strb = w_held_q ? w_strb_q : bus.wstrb;
    assign commit  = (aw_held_q || aw_fire) && (w_held_q || w_fire) && (wr_state_q == WrIdle);

    assign wr_idx = wr_addr[ADDR_WIDTH-1:OFFS];
    assign rd_idx = bus.araddr[ADDR_WIDTH-1:OFFS];
    assign wr_hit = {1'b0, wr_idx} < NumRegsCmp;
    assign rd_hit = {1'b0, rd_idx} < NumRegsCmp;
    assign unused_addr_lsbs = ^{wr_addr[OFFS-1:0], bus.araddr[OFFS-1:0]};

    // Out-of-range indices match no register, so they read as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_word = regs_q[i];
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q   <= WrIdle;
            ready_en_q   <= 1'b0;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bresp_q      <= 2'b00;
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
        end else begin
            ready_en_q   <= 1'b1;
            reg_wr_pulse <= '0;
            if (aw_fire) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= bus.awaddr;
            end
            if (w_fire) begin
                w_held_q <= 1'b1;
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end
            unique case (wr_state_q)
                WrIdle: begin
                    if (commit) begin
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        wr_state_q <= WrResp;
                        bresp_q    <= wr_hit ? RespOkay : RespOor;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (wr_idx == IDX_W'(i)) begin
                                reg_wr_pulse[i] <= 1'b1;
                                for (int b = 0; b < STRB_W; b++) begin
                                    if (wr_strb[b]) regs_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                                end
                            end
                        end
                    end
                end
                WrResp: begin
                    if (bus.bready) wr_state_q <= WrIdle;
                end
                default: wr_state_q <= WrIdle;
            endcase
        end
    end

    // Reads sample regs_q before any same-edge commit lands, returning the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RdIdle;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            unique case (rd_state_q)
                RdIdle: begin
                    if (ar_fire) begin
                        rdata_q    <= rd_word;
                        rresp_q    <= rd_hit ? RespOkay : RespOor;
                        rd_state_q <= RdData;
                    end
                end
                RdData: begin
                    if (bus.rready) rd_state_q <= RdIdle;
                end
                default: rd_state_q <= RdIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_kanagawa_axi4_lite_responder.sv
// Bench for kanagawa_axi4_lite_responder: directed scenarios plus random traffic against a model.
module tb_kanagawa_axi4_lite_responder;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam int unsigned SW = DW / 8;
`ifdef KANAGAWA_AXIL_RESPONDER_SLVERR_EN
    localparam logic [1:0] OorResp = 2'b10;
`else
    localparam logic [1:0] OorResp = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0]    reg_wr_pulse;

    always #5 clk = ~clk;

    kanagawa_axi4_lite_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    kanagawa_axi4_lite_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RESET_VALUE('0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .reg_out     (reg_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: transaction-level state advanced once per clock
    logic [DW-1:0] m_regs [NR];
    bit            m_ready_en, m_aw_pend, m_w_pend, m_b_valid, m_r_valid;
    logic [AW-1:0] m_aw_addr;
    logic [DW-1:0] m_w_data, m_rdata;
    logic [SW-1:0] m_w_strb;
    logic [1:0]    m_bresp, m_rresp;
    logic [NR-1:0] m_pulse;

    initial begin
        forever begin
            bit aw_rdy, w_rdy, ar_rdy, cur_b;
            int unsigned idx;
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < NR; i++) m_regs[i] = '0;
                m_ready_en = 0; m_aw_pend = 0; m_w_pend = 0; m_b_valid = 0; m_r_valid = 0;
                m_pulse = '0;
                chk("rst_bresp", 64'(bus.bresp), 64'(0));
                chk("rst_rresp", 64'(bus.rresp), 64'(0));
                chk("rst_rdata", 64'(bus.rdata), 64'(0));
            end
            aw_rdy = m_ready_en && !m_aw_pend && !m_b_valid;
            w_rdy  = m_ready_en && !m_w_pend && !m_b_valid;
            ar_rdy = m_ready_en && !m_r_valid;
            chk("awready", 64'(bus.awready), 64'(aw_rdy));
            chk("wready", 64'(bus.wready), 64'(w_rdy));
            chk("arready", 64'(bus.arready), 64'(ar_rdy));
            chk("bvalid", 64'(bus.bvalid), 64'(m_b_valid));
            chk("rvalid", 64'(bus.rvalid), 64'(m_r_valid));
            chk("pulse", 64'(reg_wr_pulse), 64'(m_pulse));
            if (m_b_valid) chk("bresp", 64'(bus.bresp), 64'(m_bresp));
            if (m_r_valid) begin
                chk("rdata", 64'(bus.rdata), 64'(m_rdata));
                chk("rresp", 64'(bus.rresp), 64'(m_rresp));
            end
            for (int i = 0; i < NR; i++) chk("reg_out", 64'(reg_out[i*DW +: DW]), 64'(m_regs[i]));
            if (rst_n) begin
                cur_b   = m_b_valid;
                m_pulse = '0;
                if (m_b_valid && bus.bready) m_b_valid = 0;
                if (m_r_valid && bus.rready) m_r_valid = 0;
                if (bus.arvalid && ar_rdy) begin
                    idx = 32'(bus.araddr) / SW;
                    m_rdata = (idx < NR) ? m_regs[idx] : '0;
                    m_rresp = (idx < NR) ? 2'b00 : OorResp;
                    m_r_valid = 1;
                end
                if (bus.awvalid && aw_rdy) begin
                    m_aw_pend = 1; m_aw_addr = bus.awaddr;
                end
                if (bus.wvalid && w_rdy) begin
                    m_w_pend = 1; m_w_data = bus.wdata; m_w_strb = bus.wstrb;
                end
                if (m_aw_pend && m_w_pend && !cur_b) begin
                    idx = 32'(m_aw_addr) / SW;
                    if (idx < NR) begin
                        for (int b = 0; b < SW; b++)
                            if (m_w_strb[b]) m_regs[idx][b*8 +: 8] = m_w_data[b*8 +: 8];
                        m_pulse[idx] = 1'b1;
                        m_bresp = 2'b00;
                    end else begin
                        m_bresp = OorResp;
                    end
                    m_b_valid = 1; m_aw_pend = 0; m_w_pend = 0;
                end
                m_ready_en = 1;
            end
        end
    end

    // Channel drivers: called at posedge+1, return at posedge+1 after the handshake edge
    task automatic send_aw(input logic [AW-1:0] a);
        bit ok = 0;
        bus.awvalid = 1'b1; bus.awaddr = a;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.awready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        if (!ok) chk("aw_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit ok = 0;
        bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.wready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        if (!ok) chk("w_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_ar(input logic [AW-1:0] a);
        bit ok = 0;
        bus.arvalid = 1'b1; bus.araddr = a;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.arready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        if (!ok) chk("ar_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [NR*DW-1:0] snap;
        bit aw_f, w_f, ar_f;
        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 1; bus.arvalid = 0; bus.araddr = '0; bus.rready = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_awready", 64'(bus.awready), 64'(0));
        chk("reset_arready", 64'(bus.arready), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_awready", 64'(bus.awready), 64'(1));

        // Same-cycle AW and W
        fork
            send_aw(12'h008);
            send_w(32'hDEADBEEF, 4'hF);
        join
        chk("t1_bvalid", 64'(bus.bvalid), 64'(1));
        chk("t1_bresp", 64'(bus.bresp), 64'(0));
        chk("t1_reg2", 64'(reg_out[2*DW +: DW]), 64'(32'hDEADBEEF));
        chk("t1_pulse", 64'(reg_wr_pulse), 64'(16'h0004));
        @(posedge clk); #1;
        chk("t1_pulse_end", 64'(reg_wr_pulse), 64'(0));

        // W three cycles ahead of AW, partial strobes
        fork
            begin
                send_w(32'h11223344, 4'h5);
                chk("t2_wready_low", 64'(bus.wready), 64'(0));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                send_aw(12'h008);
            end
        join
        chk("t2_reg2", 64'(reg_out[2*DW +: DW]), 64'(32'hDE22BE44));
        chk("t2_pulse", 64'(reg_wr_pulse), 64'(16'h0004));
        @(posedge clk); #1;

        // Read with rready stalled
        bus.rready = 0;
        send_ar(12'h008);
        for (int i = 0; i < 5; i++) begin
            chk("t3_rvalid", 64'(bus.rvalid), 64'(1));
            chk("t3_rdata", 64'(bus.rdata), 64'(32'hDE22BE44));
            chk("t3_arready", 64'(bus.arready), 64'(0));
            @(posedge clk); #1;
        end
        bus.rready = 1;
        @(posedge clk); #1;
        chk("t3_rvalid_clr", 64'(bus.rvalid), 64'(0));

        // Same-edge write and read of register 3
        fork
            send_aw(12'h00C);
            send_w(32'hCAFEF00D, 4'hF);
            send_ar(12'h00C);
        join
        chk("t4_rdata_old", 64'(bus.rdata), 64'(0));
        chk("t4_reg3", 64'(reg_out[3*DW +: DW]), 64'(32'hCAFEF00D));
        @(posedge clk); #1;
        send_ar(12'h00C);
        chk("t4_rdata_new", 64'(bus.rdata), 64'(32'hCAFEF00D));

        // Out-of-range write and read
        snap = reg_out;
        fork
            send_aw(12'h040);
            send_w(32'h12345678, 4'hF);
        join
        chk("t5_bresp", 64'(bus.bresp), 64'(OorResp));
        chk("t5_pulse", 64'(reg_wr_pulse), 64'(0));
        chk("t5_regs", 64'(reg_out == snap), 64'(1));
        @(posedge clk); #1;
        send_ar(12'h040);
        chk("t5_rresp", 64'(bus.rresp), 64'(OorResp));
        chk("t5_rdata", 64'(bus.rdata), 64'(0));

        // Reset while a write response is stalled
        bus.bready = 0;
        fork
            send_aw(12'h004);
            send_w(32'h55AA55AA, 4'hF);
        join
        chk("t6_bvalid_pre", 64'(bus.bvalid), 64'(1));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_bvalid_async", 64'(bus.bvalid), 64'(0));
        chk("t6_awready", 64'(bus.awready), 64'(0));
        for (int i = 0; i < NR; i++) chk("t6_regs", 64'(reg_out[i*DW +: DW]), 64'(0));
        bus.bready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t6_ready_low", 64'(bus.awready), 64'(0));
        @(posedge clk); #1;
        chk("t6_ready_up", 64'(bus.awready), 64'(1));
        chk("t6_no_resp", 64'(bus.bvalid), 64'(0));

        // Random traffic, then drain without starting new requests
        for (int cyc = 0; cyc < 460; cyc++) begin
            bit fresh;
            fresh = cyc < 400;
            @(negedge clk);
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            ar_f = bus.arvalid && bus.arready;
            @(posedge clk); #1;
            if (!bus.awvalid || aw_f) begin
                bus.awvalid = fresh && (($urandom % 3) == 0);
                bus.awaddr  = AW'($urandom_range(0, 'h5F));
            end
            if (!bus.wvalid || w_f) begin
                bus.wvalid = fresh && (($urandom % 3) == 0);
                bus.wdata  = DW'($urandom);
                bus.wstrb  = SW'($urandom);
            end
            if (!bus.arvalid || ar_f) begin
                bus.arvalid = fresh && (($urandom % 2) == 0);
                bus.araddr  = AW'($urandom_range(0, 'h5F));
            end
            bus.bready = fresh ? 1'(($urandom % 4) != 0) : 1'b1;
            bus.rready = fresh ? 1'(($urandom % 4) != 0) : 1'b1;
        end
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
